// File: rtl/sd_mode_ctl.sv
// Scandoubler mode controller: measures the hsync period, classifies the source as 15/31 kHz,
// selects the scandoubler path, blanks video across mode changes and owns the scanline setting.
module sd_mode_ctl #(
   parameter int HS_THRESH    = 1536,
   parameter int STABLE_LINES = 8,
   parameter int BLANK_FRAMES = 2,
   parameter int TIMEOUT      = 4095
) (
   input  logic        clk_x2,
   input  logic        reset_n,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic [1:0]  force_mode,
   input  logic        sl_btn,
   output logic        sd_enable,
   output logic [1:0]  scanlines,
   output logic        blank,
   output logic        mode_valid,
   output logic [11:0] line_len
);

   // state   | meaning
   // NOSIG   | no hsync seen or signal lost; blanked, not valid
   // MEASURE | counting stable lines to commit the first class
   // SWITCH  | path changing; blanked until BLANK_FRAMES vsync edges
   // LOCKED  | video passes; watching for class or force changes
   typedef enum logic [1:0] {NOSIG, MEASURE, SWITCH, LOCKED} state_t;

   state_t      state;
   logic        hs_q, vs_q, sl_q;
   logic [11:0] pcnt;
   logic [7:0]  run_cnt;
   logic [7:0]  fcnt;
   logic        last_cls;
   logic        auto_cls;
   logic [1:0]  sl_reg;

   logic        hs_fall, vs_fall, sl_rise;
   logic [11:0] pcnt_inc;
   logic        cls;
   logic [7:0]  run_nxt;
   logic        run_full;
   logic        timeout;
   logic        commit;
   logic        retarget;
   logic        enter_sw;
   logic        tgt_new;
   logic        sd_nxt;
   logic [1:0]  sl_nxt;

   function automatic logic tgt_of(input logic [1:0] fm, input logic auto_c);
      case (fm)
         2'b01:   tgt_of = 1'b1;
         2'b10:   tgt_of = 1'b0;
         default: tgt_of = auto_c;
      endcase
   endfunction

   assign hs_fall  = hs_q & ~hs_in;
   assign vs_fall  = vs_q & ~vs_in;
   assign sl_rise  = ~sl_q & sl_btn;
   assign pcnt_inc = (pcnt == 12'hfff) ? pcnt : pcnt + 12'd1;
   assign cls      = ({20'd0, pcnt_inc} >= 32'(HS_THRESH));

   // run_cnt is 0 only after reset or loss, so the first line always starts a run of 1
   always_comb begin
      run_nxt = 8'd1;
      if (cls == last_cls && run_cnt != 8'd0)
         run_nxt = ({24'd0, run_cnt} >= 32'(STABLE_LINES)) ? run_cnt : run_cnt + 8'd1;
   end

   assign run_full = ({24'd0, run_nxt} >= 32'(STABLE_LINES));
   assign timeout  = (state != NOSIG) && ({20'd0, pcnt} >= 32'(TIMEOUT));
   assign commit   = hs_fall && run_full &&
                     (state == MEASURE || (state == LOCKED && cls != auto_cls));
   assign retarget = (state == LOCKED || state == SWITCH) &&
                     (tgt_of(force_mode, auto_cls) != sd_enable);
   assign enter_sw = !timeout && (commit || retarget);
   assign tgt_new  = tgt_of(force_mode, commit ? cls : auto_cls);
   assign sd_nxt   = enter_sw ? tgt_new : sd_enable;
   assign sl_nxt   = sl_rise ? sl_reg + 2'd1 : sl_reg;

   always_ff @(posedge clk_x2 or negedge reset_n) begin
      if (!reset_n) begin
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         sl_q      <= 1'b0;
         pcnt      <= 12'd0;
         line_len  <= 12'd0;
         run_cnt   <= 8'd0;
         last_cls  <= 1'b0;
         sl_reg    <= 2'b00;
         scanlines <= 2'b00;
      end else begin
         hs_q      <= hs_in;
         vs_q      <= vs_in;
         sl_q      <= sl_btn;
         sl_reg    <= sl_nxt;
         scanlines <= sd_nxt ? sl_nxt : 2'b00;
         if (hs_fall) begin
            pcnt     <= 12'd0;
            line_len <= pcnt_inc;
            last_cls <= cls;
         end else begin
            pcnt <= pcnt_inc;
         end
         if (timeout)
            run_cnt <= 8'd0;
         else if (hs_fall)
            run_cnt <= run_nxt;
      end
   end

   always_ff @(posedge clk_x2 or negedge reset_n) begin
      if (!reset_n) begin
         state      <= NOSIG;
         sd_enable  <= 1'b0;
         fcnt       <= 8'd0;
         auto_cls   <= 1'b0;
         blank      <= 1'b1;
         mode_valid <= 1'b0;
      end else if (timeout) begin
         state      <= NOSIG;
         blank      <= 1'b1;
         mode_valid <= 1'b0;
      end else if (enter_sw) begin
         state      <= SWITCH;
         sd_enable  <= tgt_new;
         fcnt       <= 8'd0;
         blank      <= 1'b1;
         mode_valid <= 1'b0;
         if (commit)
            auto_cls <= cls;
      end else begin
         case (state)
            NOSIG: begin
               if (hs_fall)
                  state <= MEASURE;
            end
            SWITCH: begin
               if (vs_fall) begin
                  if (32'(fcnt) + 32'd1 >= 32'(BLANK_FRAMES)) begin
                     state      <= LOCKED;
                     blank      <= 1'b0;
                     mode_valid <= 1'b1;
                  end else begin
                     fcnt <= fcnt + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sd_mode_ctl.md
# sd_mode_ctl

Mode controller for the scandoubler video path. It measures the incoming line period on `hs_in`, classifies the source as 15 kHz or 31 kHz, and decides whether the scandoubler path is selected. It blanks video across mode changes and owns the 2-bit scanline setting fed to the scandoubler. It sits between the video shifter sync outputs and the scandoubler/bypass output mux, clocked by the scandoubler's `clk_x2`.

## Interface
Parameters:
- `HS_THRESH`, default 1536: line period in `clk_x2` cycles; a period ≥ this value is classified 15 kHz, a shorter one 31 kHz.
- `STABLE_LINES`, default 8: number of consecutive same-class lines needed to commit a class.
- `BLANK_FRAMES`, default 2: number of `vs_in` falling edges held blanked after a switch.
- `TIMEOUT`, default 4095: period count at which the signal is declared lost.

Ports:
- `clk_x2`, in, 1: sole clock (32 MHz).
- `reset_n`, in, 1: asynchronous, active-low reset.
- `hs_in`, in, 1: active-low hsync, synchronous to `clk_x2`.
- `vs_in`, in, 1: active-low vsync, synchronous to `clk_x2`.
- `force_mode`, in, 2: 00 = auto, 01 = force 15 kHz, 10 = force 31 kHz, 11 = auto.
- `sl_btn`, in, 1: level input; each rising edge advances the scanline setting.
- `sd_enable`, out, 1: 1 selects the scandoubler path (source is 15 kHz).
- `scanlines`, out, 2: scanline setting sent to the scandoubler.
- `blank`, out, 1: 1 forces video output to black.
- `mode_valid`, out, 1: 1 when the controller is locked.
- `line_len`, out, 12: last measured line period in `clk_x2` cycles.

## Operation
Line measurement:
- A 12-bit `pcnt` increments every cycle and saturates at 4095.
- On an `hs_in` falling edge (previous sample 1, current sample 0):
  - `line_len <= pcnt + 1` (saturating);
  - `pcnt <= 0`;
  - the line class is `cls = (pcnt + 1 >= HS_THRESH)`, 1 meaning 15 kHz.
- `run_cnt` counts consecutive lines with equal `cls` (1..STABLE_LINES, saturating). A class change resets it to 1.
- Target class `tgt`: `force_mode` 01 gives 1, 10 gives 0, otherwise the committed auto class.

State machine (2-bit state):
- **NOSIG**: `blank` = 1, `mode_valid` = 0. The first hsync falling edge moves to MEASURE with `run_cnt` = 1.
- **MEASURE**: when `run_cnt` reaches STABLE_LINES, commit `cls` and enter SWITCH. This happens whether or not the class changed.
- **SWITCH**:
  - `blank` = 1, `mode_valid` = 0.
  - On entry, `sd_enable <= tgt` and `fcnt <= 0`.
  - Each `vs_in` falling edge increments `fcnt`. When `fcnt` reaches BLANK_FRAMES, go to LOCKED.
- **LOCKED**:
  - `blank` = 0, `mode_valid` = 1.
  - STABLE_LINES consecutive lines whose `cls` differs from the committed class: commit the new class and go to SWITCH. A single odd line does not switch.
  - A change of `force_mode` that changes `tgt`: go to SWITCH next cycle. A change that leaves `tgt` equal does nothing.
- **Any state except NOSIG**: when `pcnt` reaches TIMEOUT, go to NOSIG; `sd_enable` holds its value.

Scanlines:
- The internal `sl_reg` advances 00→01→10→11→00 on each `sl_btn` rising edge, in any state.
- Output `scanlines = sd_enable ? sl_reg : 2'b00`. The stored value is preserved while the path is bypassed.

## Timing
- Reset values: state NOSIG, `sd_enable` 0, `scanlines` 00 (`sl_reg` 00), `blank` 1, `mode_valid` 0, `line_len` 0, `pcnt` 0, `run_cnt` 0.
- All outputs are registered and change 1 cycle after the cycle in which the triggering edge is sampled.
- Edge detectors use one registered copy of `hs_in`, `vs_in` and `sl_btn`. Their previous-value registers reset to 1, 1 and 0 respectively.
- Lock latency from the first hsync edge of a stable source: STABLE_LINES lines, plus BLANK_FRAMES vsync edges, plus 1 cycle.
- Simultaneous events:
  - Timeout has priority over every other transition.
  - A line-commit and a `force_mode` change in the same cycle produce a single SWITCH entry, using the new `tgt`.
  - A `vs_in` edge on the same cycle as SWITCH entry is not counted.
- A hsync edge coinciding with `pcnt` = 4095 records `line_len` = 4095.
- Reset asserted mid-SWITCH or mid-LOCKED returns everything to the reset values immediately, since reset is asynchronous.

## Test plan
- **Reset**: assert `reset_n` = 0 mid-frame → all outputs at their reset values within the same cycle; after release, `blank` = 1 and `mode_valid` = 0.
- **15 kHz lock**: hsync period 2048 cycles, vsync every 312 lines, `force_mode` = 00 → `line_len` = 2048; after 8 lines `sd_enable` = 1; `blank` drops exactly 1 cycle after the 2nd vsync falling edge; `mode_valid` = 1.
- **Mode change**: locked at 2048, then switch the source to 1024-cycle lines → no change for 7 lines; on the 8th line, SWITCH with `sd_enable` = 0 and `blank` = 1, then LOCKED after 2 frames. A single 1024-cycle glitch line causes no switch.
- **Signal loss**: stop hsync while LOCKED → NOSIG, `blank` = 1, exactly 1 cycle after `pcnt` reaches 4095; `sd_enable` is unchanged.
- **Forced mode**: locked at 15 kHz, then set `force_mode` = 10 → SWITCH next cycle with `sd_enable` = 0. Setting `force_mode` = 01 while auto is already 15 kHz → no SWITCH.
- **Scanlines**: 5 `sl_btn` pulses with `sd_enable` = 1 → `scanlines` steps 01, 10, 11, 00, 01. With `sd_enable` = 0, output reads 00 but `sl_reg` keeps advancing and reappears after the next switch to 15 kHz.
